mem_port_arbiter: RTL

- Sequences the CPU's instruction-fetch and data-access requests onto one shared SRAM-like memory port.
- Sits between the pipeline (fetch stage, and the memory stage carrying byte-lane select and replicated store data from the execute stage) and the memory interface.
- Allows one outstanding transaction at a time. Data requests have priority over fetch.
- Stores with an all-zero byte select (misaligned address) are completed locally without touching memory.

---
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter: serialises instruction-fetch and data requests
// onto a single SRAM-like port. There is one outstanding transaction at a time,
// and data requests take priority over fetches. A store with an all-zero byte
// select is completed locally as an address error and never reaches memory.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    // fetch side
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_data_ok,
    // data side
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_sel,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_data_ok,
    output logic              addr_err,
    output logic              stall,
    // memory side
    output logic              mem_req,
    output logic              mem_wr,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DREQ  = 3'd1,
        ST_DWAIT = 3'd2,
        ST_IREQ  = 3'd3,
        ST_IWAIT = 3'd4,
        ST_DERR  = 3'd5
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic                mem_req_r;
    logic                mem_wr_r;
    logic [3:0]          mem_wstrb_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [DATA_W-1:0]   mem_wdata_r;
    logic                addr_err_r;
    logic                grant_data_s;
    logic                grant_inst_s;
    logic                misaligned_s;

    // Next-state decode and grant selection; data wins over fetch in IDLE
    always_comb begin
        next_state_s = state_r;
        grant_data_s = 1'b0;
        grant_inst_s = 1'b0;
        misaligned_s = data_req && data_wr && (data_sel == 4'b0000);
        case (state_r)
            ST_IDLE: begin
                if (misaligned_s) begin
                    next_state_s = ST_DERR;
                end else if (data_req) begin
                    next_state_s = ST_DREQ;
                    grant_data_s = 1'b1;
                end else if (inst_req) begin
                    next_state_s = ST_IREQ;
                    grant_inst_s = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DREQ: begin
                if (mem_addr_ok) begin
                    next_state_s = ST_DWAIT;
                end else begin
                    next_state_s = ST_DREQ;
                end
            end
            ST_IREQ: begin
                if (mem_addr_ok) begin
                    next_state_s = ST_IWAIT;
                end else begin
                    next_state_s = ST_IREQ;
                end
            end
            ST_DWAIT: begin
                if (mem_data_ok) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DWAIT;
                end
            end
            ST_IWAIT: begin
                if (mem_data_ok) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_IWAIT;
                end
            end
            ST_DERR: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered memory-port fields latched at grant time
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            mem_req_r   <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_wstrb_r <= 4'b0000;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            addr_err_r  <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            mem_req_r  <= (next_state_s == ST_DREQ) || (next_state_s == ST_IREQ);
            addr_err_r <= (next_state_s == ST_DERR);
            if (grant_data_s) begin
                mem_addr_r  <= data_addr;
                mem_wr_r    <= data_wr;
                mem_wstrb_r <= data_wr ? data_sel : 4'b0000;
                mem_wdata_r <= data_wdata;
            end else if (grant_inst_s) begin
                mem_addr_r  <= inst_addr;
                mem_wr_r    <= 1'b0;
                mem_wstrb_r <= 4'b0000;
                mem_wdata_r <= mem_wdata_r;
            end else begin
                mem_addr_r  <= mem_addr_r;
                mem_wr_r    <= mem_wr_r;
                mem_wstrb_r <= mem_wstrb_r;
                mem_wdata_r <= mem_wdata_r;
            end
        end
    end

    // Completion strobes and read-data pass-through; responses only count in the WAIT states
    always_comb begin
        data_data_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_rdata   = '0;
        inst_rdata   = '0;
        if ((state_r == ST_DWAIT) && mem_data_ok) begin
            data_data_ok = 1'b1;
            data_rdata   = mem_rdata;
        end else if (state_r == ST_DERR) begin
            data_data_ok = 1'b1;
            data_rdata   = '0;
        end else begin
            data_data_ok = 1'b0;
            data_rdata   = '0;
        end
        if ((state_r == ST_IWAIT) && mem_data_ok) begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem_rdata;
        end else begin
            inst_data_ok = 1'b0;
            inst_rdata   = '0;
        end
    end

    // Pipeline stall while any request is still waiting for its completion
    always_comb begin
        stall = (data_req && !data_data_ok) || (inst_req && !inst_data_ok);
    end

    assign mem_req   = mem_req_r;
    assign mem_wr    = mem_wr_r;
    assign mem_wstrb = mem_wstrb_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign addr_err  = addr_err_r;

endmodule
